// File: rtl/id_issue.sv
// Decode/issue stage of the RV32I core: decodes register usage, tracks pending
// writes in a scoreboard, stalls RAW/WAW hazards and fills the ID/EX register.
module id_issue #(
    parameter int REG_COUNT  = 32,
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = $clog2(REG_COUNT),
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ifu_valid_i,
    output logic                  ifu_ready_o,
    input  logic [WORD_SIZE-1:0]  ifu_instr_i,
    input  logic [WORD_SIZE-1:0]  ifu_pc_i,
    output logic [REG_ADDR_W-1:0] rf_raddr0_o,
    output logic [REG_ADDR_W-1:0] rf_raddr1_o,
    input  logic [WORD_SIZE-1:0]  rf_rdata0_i,
    input  logic [WORD_SIZE-1:0]  rf_rdata1_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  flush_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output logic [WORD_SIZE-1:0]  ex_pc_o,
    output logic [WORD_SIZE-1:0]  ex_instr_o,
    output logic [WORD_SIZE-1:0]  ex_rs1_data_o,
    output logic [WORD_SIZE-1:0]  ex_rs2_data_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  ex_we_o,
    output logic                  ex_illegal_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  pc;
        logic [WORD_SIZE-1:0]  instr;
        logic [WORD_SIZE-1:0]  rs1_data;
        logic [WORD_SIZE-1:0]  rs2_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  illegal;
    } idex_t;

    idex_t                  idex_q, idex_d;
    logic                   ex_valid_q, ex_valid_d;
    logic [REG_COUNT-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic [6:0]             opcode;
    logic [REG_ADDR_W-1:0]  rs1, rs2, rd;
    logic                   use_rs1, use_rs2, use_rd, illegal;
    logic                   we, rs1_busy, rs2_busy, rd_busy, hazard, space, issue;

    assign opcode = ifu_instr_i[6:0];
    assign rs1    = ifu_instr_i[19:15];
    assign rs2    = ifu_instr_i[24:20];
    assign rd     = ifu_instr_i[11:7];

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_REG:                    begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
            OP_IMM, OP_LOAD, OP_JALR:  begin use_rs1 = 1'b1; use_rd = 1'b1; end
            OP_STORE, OP_BRANCH:       begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JAL, OP_LUI, OP_AUIPC:  use_rd = 1'b1;
            default:                   illegal = 1'b1;
        endcase
    end

    // A same-cycle writeback is already visible on the read data, so it masks the pending bit.
    assign rs1_busy = use_rs1 && (rs1 != '0) && sb_q[rs1] && !(wb_valid_i && wb_rd_i == rs1);
    assign rs2_busy = use_rs2 && (rs2 != '0) && sb_q[rs2] && !(wb_valid_i && wb_rd_i == rs2);
    assign we       = use_rd && (rd != '0);
    assign rd_busy  = we && sb_q[rd] && !(wb_valid_i && wb_rd_i == rd);
    assign hazard   = rs1_busy || rs2_busy || rd_busy;

    assign space       = !ex_valid_q || ex_ready_i;
    assign ifu_ready_o = space && !hazard && !flush_i;
    assign issue       = ifu_valid_i && ifu_ready_o;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        idex_d      = idex_q;
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;

        if (issue) begin
            ex_valid_d       = 1'b1;
            idex_d.pc        = ifu_pc_i;
            idex_d.instr     = ifu_instr_i;
            idex_d.rs1_data  = (rs1 == '0) ? '0 : rf_rdata0_i;
            idex_d.rs2_data  = (rs2 == '0) ? '0 : rf_rdata1_i;
            idex_d.rd        = use_rd ? rd : '0;
            idex_d.we        = we;
            idex_d.illegal   = illegal;
        end else if (flush_i || ex_ready_i) begin
            ex_valid_d = 1'b0;
        end

        // Clears first so that a set in the same cycle wins.
        if (wb_valid_i) sb_d[wb_rd_i] = 1'b0;
        if (flush_i && ex_valid_q && idex_q.we) sb_d[idex_q.rd] = 1'b0;
        if (issue && we) sb_d[rd] = 1'b1;
        sb_d[0] = 1'b0;

        if (ifu_valid_i && hazard && !flush_i && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            // NOTE: the scoreboard is a flop vector, not a RAM, so reset clears it like any other state.
            ex_valid_q  <= 1'b0;
            idex_q      <= '0;
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            idex_q      <= idex_d;
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_raddr0_o   = rs1;
    assign rf_raddr1_o   = rs2;
    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = idex_q.pc;
    assign ex_instr_o    = idex_q.instr;
    assign ex_rs1_data_o = idex_q.rs1_data;
    assign ex_rs2_data_o = idex_q.rs2_data;
    assign ex_rd_o       = idex_q.rd;
    assign ex_we_o       = idex_q.we;
    assign ex_illegal_o  = idex_q.illegal;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_issue.sv
// Scoreboard bench for id_issue: directed instructions push expected ID/EX
// contents; a monitor pops and compares each time EX consumes the register.
module tb_id_issue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ifu_valid_i, ifu_ready_o;
    logic [31:0] ifu_instr_i, ifu_pc_i;
    logic [4:0]  rf_raddr0_o, rf_raddr1_o;
    logic [31:0] rf_rdata0_i, rf_rdata1_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        flush_i;
    logic        ex_valid_o, ex_ready_i;
    logic [31:0] ex_pc_o, ex_instr_o, ex_rs1_data_o, ex_rs2_data_o;
    logic [4:0]  ex_rd_o;
    logic        ex_we_o, ex_illegal_o;
    logic [31:0] stall_cnt_o;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    id_issue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_valid_i(ifu_valid_i), .ifu_ready_o(ifu_ready_o),
        .ifu_instr_i(ifu_instr_i), .ifu_pc_i(ifu_pc_i),
        .rf_raddr0_o(rf_raddr0_o), .rf_raddr1_o(rf_raddr1_o),
        .rf_rdata0_i(rf_rdata0_i), .rf_rdata1_i(rf_rdata1_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_illegal_o(ex_illegal_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [4:0] rd, input logic we, input logic ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    // Monitor: EX consumes the ID/EX register when valid && ready (and not flushed).
    always @(negedge clk_i) begin
        if (!rst_i && ex_valid_o && ex_ready_i && !flush_i) begin
            exp_t act;
            act = mk(ex_pc_o, ex_instr_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_we_o, ex_illegal_o);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL idex_unexpected: got pc=0x%08h instr=0x%08h expected no transfer", ex_pc_o, ex_instr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL idex_pc%08h: got pc=%h in=%h r1=%h r2=%h rd=%0d we=%b il=%b expected pc=%h in=%h r1=%h r2=%h rd=%0d we=%b il=%b",
                             e.pc, act.pc, act.instr, act.rs1, act.rs2, act.rd, act.we, act.ill,
                             e.pc, e.instr, e.rs1, e.rs2, e.rd, e.we, e.ill);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents an instruction until accepted (bounded); returns cycles spent waiting.
    task automatic issue(input exp_t e, input logic [31:0] d0, input logic [31:0] d1,
                         input bit push, output int waited);
        waited      = 0;
        ifu_valid_i = 1'b1;
        ifu_instr_i = e.instr;
        ifu_pc_i    = e.pc;
        rf_rdata0_i = d0;
        rf_rdata1_i = d1;
        forever begin
            @(negedge clk_i);
            if (ifu_ready_o) break;
            waited++;
            if (waited > 20) begin
                n_cmp++;
                n_fail++;
                $display("FAIL issue_timeout: got no acceptance of pc=0x%08h expected acceptance within 20 cycles", e.pc);
                ifu_valid_i = 1'b0;
                return;
            end
            tick();
        end
        if (push) exp_q.push_back(e);
        tick();
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid_i = 1'b1;
        wb_rd_i    = r;
        tick();
        wb_valid_i = 1'b0;
    endtask

    initial begin
        int   w;
        exp_t e;
        rst_i = 1'b1; ifu_valid_i = 1'b0; ifu_instr_i = '0; ifu_pc_i = '0;
        rf_rdata0_i = '0; rf_rdata1_i = '0; wb_valid_i = 1'b0; wb_rd_i = '0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        check("rst_ex_pc", ex_pc_o, 32'd0);
        check("rst_ex_instr", ex_instr_o, 32'd0);
        check("rst_ex_we", 32'(ex_we_o), 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_ifu_ready", 32'(ifu_ready_o), 32'd1);
        tick();

        // Back-to-back independent issue
        issue(mk(32'h100, enc_addi(5'd1, 5'd0, 12'd1), 32'h0, 32'h22, 5'd1, 1'b1, 1'b0), 32'h11, 32'h22, 1'b1, w);
        check("b2b_wait0", 32'(w), 32'd0);
        issue(mk(32'h104, enc_addi(5'd2, 5'd0, 12'd2), 32'h0, 32'h22, 5'd2, 1'b1, 1'b0), 32'h11, 32'h22, 1'b1, w);
        check("b2b_wait1", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        check("b2b_ex_valid", 32'(ex_valid_o), 32'd1);
        check("b2b_stall_cnt", stall_cnt_o, 32'd0);
        tick();
        wb(5'd1);
        wb(5'd2);

        // RAW stall on x5, released by same-cycle writeback
        issue(mk(32'h200, enc_addi(5'd5, 5'd0, 12'd7), 32'h0, 32'h22, 5'd5, 1'b1, 1'b0), 32'h11, 32'h22, 1'b1, w);
        ifu_instr_i = enc_add(5'd6, 5'd5, 5'd5);
        ifu_pc_i    = 32'h204;
        rf_rdata0_i = 32'hAAAA;
        rf_rdata1_i = 32'hAAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("raw_ready_low", 32'(ifu_ready_o), 32'd0);
            tick();
        end
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        issue(mk(32'h204, enc_add(5'd6, 5'd5, 5'd5), 32'h77, 32'h77, 5'd6, 1'b1, 1'b0), 32'h77, 32'h77, 1'b1, w);
        check("raw_release_wait", 32'(w), 32'd0);
        wb_valid_i  = 1'b0;
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        check("raw_stall_cnt", stall_cnt_o, 32'd3);
        tick();
        wb(5'd6);

        // Backpressure: ID/EX held while EX is not ready
        ex_ready_i = 1'b0;
        issue(mk(32'h300, enc_addi(5'd9, 5'd0, 12'd3), 32'h0, 32'h2B, 5'd9, 1'b1, 1'b0), 32'h1A, 32'h2B, 1'b1, w);
        ifu_instr_i = enc_addi(5'd10, 5'd0, 12'd4);
        ifu_pc_i    = 32'h304;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_ready_low", 32'(ifu_ready_o), 32'd0);
            check("bp_ex_valid", 32'(ex_valid_o), 32'd1);
            check("bp_ex_pc", ex_pc_o, 32'h300);
            check("bp_ex_instr", ex_instr_o, enc_addi(5'd9, 5'd0, 12'd3));
            check("bp_ex_rs2", ex_rs2_data_o, 32'h2B);
            tick();
        end
        ex_ready_i = 1'b1;
        issue(mk(32'h304, enc_addi(5'd10, 5'd0, 12'd4), 32'h0, 32'h3C, 5'd10, 1'b1, 1'b0), 32'h3C, 32'h3C, 1'b1, w);
        check("bp_release_wait", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_stall_cnt", stall_cnt_o, 32'd3);
        tick();

        // x0: never a hazard, never written, read as zero
        issue(mk(32'h400, enc_addi(5'd0, 5'd0, 12'd1), 32'h0, 32'h12345678, 5'd0, 1'b0, 1'b0),
              32'hDEADBEEF, 32'h12345678, 1'b1, w);
        check("x0_wait0", 32'(w), 32'd0);
        issue(mk(32'h404, enc_add(5'd1, 5'd0, 5'd0), 32'h0, 32'h0, 5'd1, 1'b1, 1'b0),
              32'hDEADBEEF, 32'hDEADBEEF, 1'b1, w);
        check("x0_wait1", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;
        tick();

        // Flush kills lw x7 in ID/EX and clears its pending bit
        ex_ready_i = 1'b0;
        issue(mk(32'h500, 32'h00002383, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0), 32'h1234, 32'h5678, 1'b0, w);
        flush_i     = 1'b1;
        ifu_instr_i = enc_add(5'd8, 5'd7, 5'd0);
        ifu_pc_i    = 32'h504;
        @(negedge clk_i);
        check("flush_ready_low", 32'(ifu_ready_o), 32'd0);
        tick();
        flush_i     = 1'b0;
        ifu_valid_i = 1'b0;
        ex_ready_i  = 1'b1;
        @(negedge clk_i);
        check("flush_ex_valid", 32'(ex_valid_o), 32'd0);
        tick();
        issue(mk(32'h504, enc_add(5'd8, 5'd7, 5'd0), 32'h5555, 32'h0, 5'd8, 1'b1, 1'b0), 32'h5555, 32'h9999, 1'b1, w);
        check("flush_sb7_clear", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_stall_cnt", stall_cnt_o, 32'd3);
        tick();

        // Set/clear collision on x3: set wins
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        issue(mk(32'h600, enc_addi(5'd3, 5'd0, 12'd1), 32'h0, 32'h22, 5'd3, 1'b1, 1'b0), 32'h11, 32'h22, 1'b1, w);
        wb_valid_i  = 1'b0;
        ifu_instr_i = enc_add(5'd4, 5'd3, 5'd0);
        ifu_pc_i    = 32'h604;
        @(negedge clk_i);
        check("coll_sb3_set", 32'(ifu_ready_o), 32'd0);
        tick();
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        issue(mk(32'h604, enc_add(5'd4, 5'd3, 5'd0), 32'h33, 32'h0, 5'd4, 1'b1, 1'b0), 32'h33, 32'h44, 1'b1, w);
        check("coll_release_wait", 32'(w), 32'd0);
        wb_valid_i  = 1'b0;
        ifu_valid_i = 1'b0;
        @(negedge clk_i);
        check("coll_stall_cnt", stall_cnt_o, 32'd4);
        tick();

        // Illegal opcode: no operands or rd used
        issue(mk(32'h700, 32'hFFFFFFFF, 32'hA0, 32'hB0, 5'd0, 1'b0, 1'b1), 32'hA0, 32'hB0, 1'b1, w);
        check("ill_wait0", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;
        tick();

        // Reset mid-operation drops ID/EX content and scoreboard
        ex_ready_i = 1'b0;
        issue(mk(32'h800, enc_addi(5'd12, 5'd0, 12'd1), 32'h0, 32'h22, 5'd12, 1'b1, 1'b0), 32'h11, 32'h22, 1'b0, w);
        ifu_valid_i = 1'b0;
        rst_i       = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_ex_valid", 32'(ex_valid_o), 32'd0);
        check("mid_rst_ex_pc", ex_pc_o, 32'd0);
        check("mid_rst_stall_cnt", stall_cnt_o, 32'd0);
        tick();
        ex_ready_i = 1'b1;
        issue(mk(32'h900, enc_add(5'd13, 5'd12, 5'd0), 32'h66, 32'h0, 5'd13, 1'b1, 1'b0), 32'h66, 32'h77, 1'b1, w);
        check("mid_rst_sb_clear", 32'(w), 32'd0);
        ifu_valid_i = 1'b0;

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
